ram_program_loader: RTL and testbench

RAM_PROGRAM_LOADER -- requirements
Module: ram_program_loader

---
 rtl/ram_program_loader.sv | 150 +++++++++++++++
 tb/tb_ram_program_loader.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_program_loader.sv
// Streams 32-bit payload words into a processor RAM through its manual-override write port.
// Optional LOADER_CHECKSUM_EN: a trailing beat carries the mod-2^32 sum of the payload for verification.
module ram_program_loader #(
  parameter logic [15:0] BASE_ADDR = 16'h0000,
  parameter int unsigned MAX_WORDS = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] in_data,
  input  logic        in_valid,
  input  logic        in_last,
  output logic        in_ready,
  output logic [15:0] manual_ram_addr,
  output logic [31:0] manual_ram_write,
  output logic        manual_readWrite,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [16:0] word_count
);

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 32;
  localparam int unsigned CW = 17;
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_WORDS);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    WRITE = 3'd2,
    CHECK = 3'd3,
    DONE  = 3'd4,
    ERROR = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] data_q, data_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          last_q, last_d;
`ifdef LOADER_CHECKSUM_EN
  logic [DW-1:0] sum_q, sum_d;
`endif

  // State and datapath registers; status flags are decoded from the next state so they are flopped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q          <= IDLE;
      ptr_q            <= BASE_ADDR;
      addr_q           <= BASE_ADDR;
      data_q           <= '0;
      cnt_q            <= '0;
      last_q           <= 1'b0;
      in_ready         <= 1'b0;
      manual_readWrite <= 1'b0;
      busy             <= 1'b0;
      done             <= 1'b0;
      error            <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      sum_q            <= '0;
`endif
    end else begin
      state_q          <= state_d;
      ptr_q            <= ptr_d;
      addr_q           <= addr_d;
      data_q           <= data_d;
      cnt_q            <= cnt_d;
      last_q           <= last_d;
      in_ready         <= (state_d == LOAD) || (state_d == CHECK);
      manual_readWrite <= (state_d == WRITE);
      busy             <= (state_d == LOAD) || (state_d == WRITE) || (state_d == CHECK);
      done             <= (state_d == DONE);
      error            <= (state_d == ERROR);
`ifdef LOADER_CHECKSUM_EN
      sum_q            <= sum_d;
`endif
    end
  end

  // Next-state and datapath updates.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    addr_d  = addr_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
`ifdef LOADER_CHECKSUM_EN
    sum_d   = sum_q;
`endif
    unique case (state_q)
      IDLE, DONE, ERROR: begin
        if (start) begin
          state_d = LOAD;
          ptr_d   = BASE_ADDR;
          cnt_d   = '0;
`ifdef LOADER_CHECKSUM_EN
          sum_d   = '0;
`endif
        end
      end
      LOAD: begin
        if (in_valid) begin
          // A beat beyond the word budget is refused rather than written.
          if (cnt_q == MAX_CNT) begin
            state_d = ERROR;
          end else begin
            addr_d  = ptr_q;
            data_d  = in_data;
            last_d  = in_last;
            state_d = WRITE;
`ifdef LOADER_CHECKSUM_EN
            sum_d   = sum_q + in_data;
`endif
          end
        end
      end
      WRITE: begin
        ptr_d = ptr_q + AW'(1);
        cnt_d = cnt_q + CW'(1);
        if (last_q) begin
`ifdef LOADER_CHECKSUM_EN
          state_d = CHECK;
`else
          state_d = DONE;
`endif
        end else begin
          state_d = LOAD;
        end
      end
      CHECK: begin
`ifdef LOADER_CHECKSUM_EN
        if (in_valid) begin
          state_d = (in_data == sum_q) ? DONE : ERROR;
        end
`else
        state_d = ERROR;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  assign manual_ram_addr  = addr_q;
  assign manual_ram_write = data_q;
  assign word_count       = cnt_q;

endmodule

// File: tb/tb_ram_program_loader.sv
// Randomized scoreboard bench for ram_program_loader: two instances (default and wrapping/small budget).
// Expectations follow LOADER_CHECKSUM_EN when the bench is built with it defined.
`timescale 1ns/1ps
module tb_ram_program_loader;

  localparam logic [15:0] BASE0 = 16'h0000;
  localparam int          MAXW0 = 256;
  localparam logic [15:0] BASE1 = 16'hFFFE;
  localparam int          MAXW1 = 3;
`ifdef LOADER_CHECKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif

  typedef struct {
    int          d;
    logic [15:0] addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    int d;
    bit done;
    bit err;
    int wc;
    int cyc;
  } res_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        start    [2];
  logic [31:0] in_data  [2];
  logic        in_valid [2];
  logic        in_last  [2];
  logic        in_ready [2];
  logic [15:0] ram_addr [2];
  logic [31:0] ram_wdata[2];
  logic        ram_rw   [2];
  logic        busy     [2];
  logic        done     [2];
  logic        error    [2];
  logic [16:0] wcount   [2];

  int n_checks = 0;
  int n_fail   = 0;

  wr_t  exp_wr[$];
  res_t exp_res[$];
  logic [31:0] wbuf[16];

  always #5 clk = ~clk;

  ram_program_loader #(.BASE_ADDR(BASE0), .MAX_WORDS(MAXW0)) dut0 (
    .clk(clk), .reset(reset), .start(start[0]), .in_data(in_data[0]), .in_valid(in_valid[0]),
    .in_last(in_last[0]), .in_ready(in_ready[0]), .manual_ram_addr(ram_addr[0]),
    .manual_ram_write(ram_wdata[0]), .manual_readWrite(ram_rw[0]), .busy(busy[0]),
    .done(done[0]), .error(error[0]), .word_count(wcount[0]));

  ram_program_loader #(.BASE_ADDR(BASE1), .MAX_WORDS(MAXW1)) dut1 (
    .clk(clk), .reset(reset), .start(start[1]), .in_data(in_data[1]), .in_valid(in_valid[1]),
    .in_last(in_last[1]), .in_ready(in_ready[1]), .manual_ram_addr(ram_addr[1]),
    .manual_ram_write(ram_wdata[1]), .manual_readWrite(ram_rw[1]), .busy(busy[1]),
    .done(done[1]), .error(error[1]), .word_count(wcount[1]));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string nm);
    n_checks++;
    n_fail++;
    $display("FAIL %s: bound expired at %0t", nm, $time);
  endtask

  // Monitor: pops the scoreboard on every RAM write pulse and at every session end.
  bit rw_prev[2];
  bit busy_prev[2];
  int bcnt[2];
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (ram_rw[d]) begin
        chk("rw_single_pulse", 32'(rw_prev[d]), 32'd0);
        chk("ready_low_in_write", 32'(in_ready[d]), 32'd0);
        if (exp_wr.size() == 0) begin
          fail_now("unexpected_write");
        end else begin
          wr_t w;
          w = exp_wr.pop_front();
          chk("write_dut", 32'(d), 32'(w.d));
          chk("write_addr", 32'(ram_addr[d]), 32'(w.addr));
          chk("write_data", ram_wdata[d], w.data);
        end
      end
      if (busy[d]) bcnt[d] = busy_prev[d] ? bcnt[d] + 1 : 1;
      if (!busy[d] && busy_prev[d]) begin
        if (exp_res.size() == 0) begin
          fail_now("unexpected_session_end");
        end else begin
          res_t r;
          r = exp_res.pop_front();
          chk("end_dut", 32'(d), 32'(r.d));
          chk("end_done", 32'(done[d]), 32'(r.done));
          chk("end_error", 32'(error[d]), 32'(r.err));
          chk("end_word_count", 32'(wcount[d]), 32'(r.wc));
          if (r.cyc >= 0) chk("busy_cycles", 32'(bcnt[d]), 32'(r.cyc));
        end
      end
      rw_prev[d]   = ram_rw[d];
      busy_prev[d] = busy[d];
    end
  end

  // Drives one session of n payload words from wbuf and predicts its writes and outcome.
  task automatic run_session(input int d, input int n, input bit has_last, input bit cont,
                             input bit bad_ck);
    int          maxw;
    logic [15:0] base;
    bit          ovf;
    int          nw;
    logic [31:0] sum;
    logic [31:0] bd[$];
    bit          bl[$];
    res_t        r;
    bit          ok;
    maxw = (d == 0) ? MAXW0 : MAXW1;
    base = (d == 0) ? BASE0 : BASE1;
    ovf  = n > maxw;
    nw   = ovf ? maxw : n;
    sum  = '0;
    for (int i = 0; i < nw; i++) begin
      wr_t w;
      w.d = d;
      w.addr = base + 16'(i);
      w.data = wbuf[i];
      exp_wr.push_back(w);
      sum += wbuf[i];
    end
    for (int i = 0; i < (ovf ? maxw + 1 : n); i++) begin
      bd.push_back(wbuf[i]);
      bl.push_back(has_last && (i == n - 1));
    end
    r.d  = d;
    r.wc = nw;
    if (ovf) begin
      r.done = 1'b0; r.err = 1'b1; r.cyc = cont ? 2 * maxw + 1 : -1;
    end else if (CK) begin
      bd.push_back(sum + (bad_ck ? 32'd1 : 32'd0));
      bl.push_back(1'b0);
      r.done = !bad_ck; r.err = bad_ck; r.cyc = cont ? 2 * n + 1 : -1;
    end else begin
      r.done = 1'b1; r.err = 1'b0; r.cyc = cont ? 2 * n : -1;
    end
    exp_res.push_back(r);

    start[d] = 1'b1;
    @(posedge clk); #1;
    start[d] = 1'b0;
    for (int i = 0; i < bd.size(); i++) begin
      in_valid[d] = 1'b1;
      in_data[d]  = bd[i];
      in_last[d]  = bl[i];
      ok = 1'b0;
      for (int k = 0; k < 20; k++) begin
        @(negedge clk);
        if (in_ready[d]) begin ok = 1'b1; break; end
      end
      if (!ok) begin
        fail_now("accept_timeout");
        break;
      end
      @(posedge clk); #1;
      if (!cont && i != bd.size() - 1) begin
        // Idle gap after a beat, optionally with a start pulse that must be ignored mid-session.
        int g;
        g = int'($urandom_range(2, 1));
        in_valid[d] = 1'b0;
        start[d] = 1'($urandom_range(1, 0));
        repeat (g) @(posedge clk);
        #1;
        start[d] = 1'b0;
      end
    end
    in_valid[d] = 1'b0;
    in_last[d]  = 1'b0;
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (!busy[d]) begin ok = 1'b1; break; end
    end
    if (!ok) fail_now("session_end_timeout");
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b1;
    for (int d = 0; d < 2; d++) begin
      start[d] = 1'b0; in_data[d] = '0; in_valid[d] = 1'b0; in_last[d] = 1'b0;
    end
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("rst_in_ready", 32'(in_ready[d]), 32'd0);
      chk("rst_addr", 32'(ram_addr[d]), (d == 0) ? 32'(BASE0) : 32'(BASE1));
      chk("rst_wdata", ram_wdata[d], 32'd0);
      chk("rst_rw", 32'(ram_rw[d]), 32'd0);
      chk("rst_busy", 32'(busy[d]), 32'd0);
      chk("rst_done", 32'(done[d]), 32'd0);
      chk("rst_error", 32'(error[d]), 32'd0);
      chk("rst_word_count", 32'(wcount[d]), 32'd0);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    // in_valid while idle must write nothing.
    in_valid[0] = 1'b1; in_data[0] = 32'hDEAD_BEEF;
    repeat (3) @(posedge clk);
    #1 in_valid[0] = 1'b0;

    wbuf[0] = 32'd11; wbuf[1] = 32'd22; wbuf[2] = 32'd33;
    run_session(0, 3, 1'b1, 1'b1, 1'b0);
    wbuf[0] = 32'hA; wbuf[1] = 32'hB; wbuf[2] = 32'hC;
    run_session(1, 3, 1'b1, 1'b1, 1'b0);
    wbuf[3] = 32'hD;
    run_session(1, 4, 1'b0, 1'b1, 1'b0);
    wbuf[0] = 32'd1; wbuf[1] = 32'd2; wbuf[2] = 32'd3;
    run_session(0, 3, 1'b1, 1'b1, 1'b0);
    run_session(0, 3, 1'b1, 1'b0, 1'b1);

    // Reset during the write cycle aborts the session without a write.
    begin
      res_t r;
      r.d = 0; r.done = 1'b0; r.err = 1'b0; r.wc = 0; r.cyc = -1;
      start[0] = 1'b1;
      @(posedge clk); #1;
      start[0] = 1'b0; in_valid[0] = 1'b1; in_data[0] = 32'h1234_5678;
      @(posedge clk); #1;
      in_valid[0] = 1'b0;
      chk("pre_rst_rw", 32'(ram_rw[0]), 32'd1);
      exp_res.push_back(r);
      reset = 1'b1;
      #1;
      chk("mid_rst_rw", 32'(ram_rw[0]), 32'd0);
      chk("mid_rst_busy", 32'(busy[0]), 32'd0);
      chk("mid_rst_ready", 32'(in_ready[0]), 32'd0);
      chk("mid_rst_addr", 32'(ram_addr[0]), 32'(BASE0));
      chk("mid_rst_wdata", ram_wdata[0], 32'd0);
      chk("mid_rst_word_count", 32'(wcount[0]), 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;
    end

    for (int t = 0; t < 16; t++) begin
      int d;
      int n;
      bit hl;
      d = int'($urandom_range(1, 0));
      n = int'($urandom_range(6, 1));
      for (int i = 0; i < 16; i++) wbuf[i] = $urandom();
      // Without a last flag a session only ends by overflowing the budget.
      hl = (n <= ((d == 0) ? MAXW0 : MAXW1)) ? 1'b1 : 1'($urandom_range(1, 0));
      run_session(d, n, hl, 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
    end

    repeat (4) @(posedge clk);
    chk("writes_outstanding", 32'(exp_wr.size()), 32'd0);
    chk("results_outstanding", 32'(exp_res.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
